// File: rtl/ysyx_24100012_mem_arbiter_if.sv
// Signal bundle between the IFU/LSU requesters, the memory arbiter and the shared RAM port.
// slave: arbiter side; master: environment side (requesters plus downstream memory).
interface ysyx_24100012_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      ifu_req_valid;
    logic                      ifu_req_ready;
    logic [ADDR_WIDTH-1:0]     ifu_addr;
    logic                      ifu_resp_valid;
    logic [DATA_WIDTH-1:0]     ifu_rdata;

    logic                      lsu_req_valid;
    logic                      lsu_req_ready;
    logic [ADDR_WIDTH-1:0]     lsu_addr;
    logic                      lsu_wen;
    logic [DATA_WIDTH-1:0]     lsu_wdata;
    logic [DATA_WIDTH/8-1:0]   lsu_wmask;
    logic                      lsu_resp_valid;
    logic [DATA_WIDTH-1:0]     lsu_rdata;

    logic                      mem_req_valid;
    logic                      mem_req_ready;
    logic [ADDR_WIDTH-1:0]     mem_addr;
    logic                      mem_wen;
    logic [DATA_WIDTH-1:0]     mem_wdata;
    logic [DATA_WIDTH/8-1:0]   mem_wmask;
    logic                      mem_resp_valid;
    logic [DATA_WIDTH-1:0]     mem_rdata;

    modport slave (
        input  ifu_req_valid, ifu_addr,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );

    modport master (
        output ifu_req_valid, ifu_addr,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/ysyx_24100012_mem_arbiter.sv
// IFU/LSU arbiter sharing one variable-latency memory port, one transaction in flight.
// Define ARB_RR_EN to alternate grants on simultaneous requests (default: LSU always wins).
module ysyx_24100012_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    ysyx_24100012_mem_arbiter_if.slave bus,
    output logic                      busy
);
    localparam int MASK_WIDTH = DATA_WIDTH / 8;
    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  wen;
        logic [DATA_WIDTH-1:0] wdata;
        logic [MASK_WIDTH-1:0] wmask;
    } mem_req_t;

    state_t                state;
    logic                  owner;
    mem_req_t              req_q;
    logic                  mem_req_valid_q;
    logic                  ifu_resp_q;
    logic                  lsu_resp_q;
    logic [DATA_WIDTH-1:0] ifu_rdata_q;
    logic [DATA_WIDTH-1:0] lsu_rdata_q;

    logic grant_lsu;
    logic grant_ifu;
    logic accepting;

    always_comb begin
`ifdef ARB_RR_EN
        // On a tie, serve whoever was not served last.
        grant_lsu = bus.lsu_req_valid && (!bus.ifu_req_valid || owner == OWN_IFU);
`else
        grant_lsu = bus.lsu_req_valid;
`endif
        grant_ifu = bus.ifu_req_valid && !grant_lsu;
    end

    // Ready is gated by reset so nothing handshakes while the block is held in reset.
    assign accepting         = rst && (state == IDLE);
    assign bus.lsu_req_ready = accepting && grant_lsu;
    assign bus.ifu_req_ready = accepting && grant_ifu;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            owner           <= OWN_LSU;
            req_q           <= '0;
            mem_req_valid_q <= 1'b0;
            ifu_resp_q      <= 1'b0;
            lsu_resp_q      <= 1'b0;
            ifu_rdata_q     <= '0;
            lsu_rdata_q     <= '0;
        end else begin
            ifu_resp_q <= 1'b0;
            lsu_resp_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_lsu) begin
                        req_q           <= '{addr: bus.lsu_addr, wen: bus.lsu_wen,
                                             wdata: bus.lsu_wdata, wmask: bus.lsu_wmask};
                        owner           <= OWN_LSU;
                        mem_req_valid_q <= 1'b1;
                        state           <= REQ;
                    end else if (grant_ifu) begin
                        req_q           <= '{addr: bus.ifu_addr, wen: 1'b0,
                                             wdata: '0, wmask: '0};
                        owner           <= OWN_IFU;
                        mem_req_valid_q <= 1'b1;
                        state           <= REQ;
                    end
                end
                REQ: begin
                    if (bus.mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state           <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_resp_valid) begin
                        if (owner == OWN_LSU) begin
                            lsu_rdata_q <= req_q.wen ? '0 : bus.mem_rdata;
                            lsu_resp_q  <= 1'b1;
                        end else begin
                            ifu_rdata_q <= bus.mem_rdata;
                            ifu_resp_q  <= 1'b1;
                        end
                        state <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_req_valid  = mem_req_valid_q;
    assign bus.mem_addr       = req_q.addr;
    assign bus.mem_wen        = req_q.wen;
    assign bus.mem_wdata      = req_q.wdata;
    assign bus.mem_wmask      = req_q.wmask;
    assign bus.ifu_resp_valid = ifu_resp_q;
    assign bus.ifu_rdata      = ifu_rdata_q;
    assign bus.lsu_resp_valid = lsu_resp_q;
    assign bus.lsu_rdata      = lsu_rdata_q;
    assign busy               = (state != IDLE);
endmodule

// File: tb/tb_ysyx_24100012_mem_arbiter.sv
// Bench for the IFU/LSU memory arbiter: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed cycle timing and data.
module tb_ysyx_24100012_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;
`ifdef ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;

    ysyx_24100012_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ysyx_24100012_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Grant rule from the arbitration policy: LSU unless a round-robin tie favours IFU.
    function automatic bit pick_lsu(input logic iv, input logic lv, input bit last_lsu);
        return lv && !(RR_EN && iv && last_lsu);
    endfunction

    // Downstream memory: ready after cfg_rdy_dly REQ cycles, response cfg_rsp_dly cycles
    // after the first post-accept cycle; optional junk responses while not yet accepted.
    int             cfg_rdy_dly = 0;
    int             cfg_rsp_dly = 0;
    bit             cfg_spur    = 1'b0;
    logic [DW-1:0]  cfg_rdata   = '0;

    initial begin
        int rd_cnt;
        int rs_cnt;
        bit waiting;
        rd_cnt  = 0;
        rs_cnt  = 0;
        waiting = 1'b0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_req_ready  = 1'b0;
            bus.mem_resp_valid = 1'b0;
            if (!rst) begin
                waiting = 1'b0;
                rd_cnt  = 0;
            end else if (waiting) begin
                if (rs_cnt == 0) begin
                    bus.mem_resp_valid = 1'b1;
                    bus.mem_rdata      = cfg_rdata;
                    waiting            = 1'b0;
                end else begin
                    rs_cnt--;
                end
            end else if (bus.mem_req_valid) begin
                if (rd_cnt >= cfg_rdy_dly) begin
                    bus.mem_req_ready = 1'b1;
                    waiting           = 1'b1;
                    rs_cnt            = cfg_rsp_dly;
                    rd_cnt            = 0;
                end else begin
                    rd_cnt++;
                    if (cfg_spur) begin
                        bus.mem_resp_valid = 1'b1;
                        bus.mem_rdata      = 32'hBAD0BAD0;
                    end
                end
            end
        end
    end

    // Transaction-level model: one transaction in flight described by flags
    // (active, accepted downstream, response pulse due), compared every negedge.
    initial begin
        bit            m_act, m_acc, m_pulse, m_own_lsu, win_lsu, win_ifu;
        logic [AW-1:0] m_addr;
        logic          m_wen;
        logic [DW-1:0] m_wdata, m_irdata, m_lrdata;
        logic [MW-1:0] m_wmask;
        m_act = 0; m_acc = 0; m_pulse = 0; m_own_lsu = 1;
        m_addr = '0; m_wen = 0; m_wdata = '0; m_wmask = '0; m_irdata = '0; m_lrdata = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_act = 0; m_acc = 0; m_pulse = 0; m_own_lsu = 1;
                m_addr = '0; m_wen = 0; m_wdata = '0; m_wmask = '0;
                m_irdata = '0; m_lrdata = '0;
            end
            win_lsu = pick_lsu(bus.ifu_req_valid, bus.lsu_req_valid, m_own_lsu);
            win_ifu = bus.ifu_req_valid && !win_lsu;
            chk("m_busy",           busy,               m_act);
            chk("m_lsu_req_ready",  bus.lsu_req_ready,  rst && !m_act && win_lsu);
            chk("m_ifu_req_ready",  bus.ifu_req_ready,  rst && !m_act && win_ifu);
            chk("m_mem_req_valid",  bus.mem_req_valid,  m_act && !m_acc);
            chk("m_mem_addr",       bus.mem_addr,       m_addr);
            chk("m_mem_wen",        bus.mem_wen,        m_wen);
            chk("m_mem_wdata",      bus.mem_wdata,      m_wdata);
            chk("m_mem_wmask",      bus.mem_wmask,      m_wmask);
            chk("m_ifu_resp_valid", bus.ifu_resp_valid, m_pulse && !m_own_lsu);
            chk("m_lsu_resp_valid", bus.lsu_resp_valid, m_pulse && m_own_lsu);
            chk("m_ifu_rdata",      bus.ifu_rdata,      m_irdata);
            chk("m_lsu_rdata",      bus.lsu_rdata,      m_lrdata);
            if (rst) begin
                if (m_pulse) begin
                    m_pulse = 0;
                    m_act   = 0;
                end else if (m_act && !m_acc) begin
                    m_acc = bus.mem_req_ready;
                end else if (m_act) begin
                    if (bus.mem_resp_valid) begin
                        m_pulse = 1;
                        if (m_own_lsu) m_lrdata = m_wen ? '0 : bus.mem_rdata;
                        else           m_irdata = bus.mem_rdata;
                    end
                end else if (win_lsu || win_ifu) begin
                    m_act     = 1;
                    m_acc     = 0;
                    m_own_lsu = win_lsu;
                    m_addr    = win_lsu ? bus.lsu_addr : bus.ifu_addr;
                    m_wen     = win_lsu && bus.lsu_wen;
                    m_wdata   = win_lsu ? bus.lsu_wdata : '0;
                    m_wmask   = win_lsu ? bus.lsu_wmask : '0;
                end
            end
        end
    end

    task automatic do_reset();
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        logic [3:0] g;
        int n, last, pulses, pc;
        bus.ifu_req_valid = 1'b0; bus.ifu_addr  = '0;
        bus.lsu_req_valid = 1'b0; bus.lsu_addr  = '0; bus.lsu_wen = 1'b0;
        bus.lsu_wdata     = '0;   bus.lsu_wmask = '0;
        #1 rst = 1'b0;
        #2;
        chk("rst_busy",          busy,              0);
        chk("rst_mem_req_valid", bus.mem_req_valid, 0);
        chk("rst_mem_addr",      bus.mem_addr,      0);
        do_reset();

        // 1: IFU fetch, fastest memory
        cfg_rdy_dly = 0; cfg_rsp_dly = 0; cfg_spur = 0; cfg_rdata = 32'h00100073;
        bus.ifu_addr = 32'h80000000; bus.ifu_req_valid = 1'b1;
        #1 chk("t1_ready_c0", bus.ifu_req_ready, 1);
        tick(); bus.ifu_req_valid = 1'b0; #1;
        chk("t1_mem_valid_c1", bus.mem_req_valid, 1);
        chk("t1_mem_addr",     bus.mem_addr,      32'h80000000);
        chk("t1_mem_wen",      bus.mem_wen,       0);
        chk("t1_mem_wmask",    bus.mem_wmask,     0);
        tick(); #1;
        chk("t1_resp_c2",      bus.ifu_resp_valid, 0);
        tick(); #1;
        chk("t1_resp_c3",      bus.ifu_resp_valid, 1);
        chk("t1_rdata",        bus.ifu_rdata,      32'h00100073);
        chk("t1_lsu_resp",     bus.lsu_resp_valid, 0);
        tick(); #1;
        chk("t1_resp_c4",      bus.ifu_resp_valid, 0);
        chk("t1_busy_c4",      busy,               0);

        // 2: LSU store with downstream stalling three cycles
        tick();
        cfg_rdy_dly = 3; cfg_rdata = 32'hCAFEF00D;
        bus.lsu_addr = 32'h80001000; bus.lsu_wen = 1'b1;
        bus.lsu_wdata = 32'hDEADBEEF; bus.lsu_wmask = 4'hF; bus.lsu_req_valid = 1'b1;
        #1 chk("t2_ready_c0", bus.lsu_req_ready, 1);
        tick();
        bus.lsu_req_valid = 1'b0; bus.lsu_addr = '0; bus.lsu_wdata = '0; bus.lsu_wmask = '0;
        for (int c = 1; c <= 4; c++) begin
            #1;
            chk("t2_mem_valid", bus.mem_req_valid, 1);
            chk("t2_mem_addr",  bus.mem_addr,      32'h80001000);
            chk("t2_mem_wdata", bus.mem_wdata,     32'hDEADBEEF);
            chk("t2_mem_wmask", bus.mem_wmask,     4'hF);
            chk("t2_mem_wen",   bus.mem_wen,       1);
            tick();
        end
        #1 chk("t2_mem_valid_wait", bus.mem_req_valid, 0);
        tick(); #1;
        chk("t2_lsu_resp",  bus.lsu_resp_valid, 1);
        chk("t2_lsu_rdata", bus.lsu_rdata,      0);
        tick(); #1;
        chk("t2_lsu_resp_end", bus.lsu_resp_valid, 0);
        bus.lsu_wen = 1'b0;
        cfg_rdy_dly = 0;

        // 3: both requesters valid every cycle for four grants
        do_reset();
        cfg_rdata = 32'h0000AAAA;
        bus.ifu_addr = 32'h80000100; bus.lsu_addr = 32'h80000200;
        bus.ifu_req_valid = 1'b1; bus.lsu_req_valid = 1'b1;
        g = '0; n = 0; last = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            #1;
            if (bus.ifu_req_ready || bus.lsu_req_ready) begin
                g[n[1:0]] = bus.lsu_req_ready;
                if (n > 0) chk("t3_spacing", c - last, 4);
                last = c;
                n++;
            end
            tick();
        end
        bus.ifu_req_valid = 1'b0; bus.lsu_req_valid = 1'b0;
        chk("t3_count", n, 4);
        chk("t3_order", g, RR_EN ? 4'b1010 : 4'b1111);
        repeat (4) tick();

        // 4: slow response with IFU holding valid and junk responses during REQ
        cfg_rdy_dly = 2; cfg_rsp_dly = 5; cfg_spur = 1'b1; cfg_rdata = 32'h11223344;
        bus.ifu_addr = 32'h80000010; bus.ifu_req_valid = 1'b1;
        #1 chk("t4_ready_c0", bus.ifu_req_ready, 1);
        pulses = 0; pc = -1;
        for (int c = 1; c <= 16; c++) begin
            tick(); #1;
            if (pc < 0) begin
                chk("t4_ifu_ready_blocked", bus.ifu_req_ready, 0);
                chk("t4_busy", busy, 1);
            end
            if (bus.ifu_resp_valid) begin
                pulses++;
                if (pc < 0) begin
                    pc = c;
                    bus.ifu_req_valid = 1'b0;
                end
            end
        end
        chk("t4_pulses",     pulses, 1);
        chk("t4_pulse_cyc",  pc, 10);
        chk("t4_rdata",      bus.ifu_rdata, 32'h11223344);
        cfg_spur = 1'b0; cfg_rdy_dly = 0; cfg_rsp_dly = 0;

        // 6: LSU load immediately followed by an IFU request
        tick();
        cfg_rdata = 32'h12345678;
        bus.lsu_addr = 32'h80000004; bus.lsu_wen = 1'b0; bus.lsu_req_valid = 1'b1;
        #1 chk("t6_lsu_ready_c0", bus.lsu_req_ready, 1);
        tick();
        bus.lsu_req_valid = 1'b0; bus.ifu_addr = 32'h80000020; bus.ifu_req_valid = 1'b1;
        #1 chk("t6_ifu_ready_c1", bus.ifu_req_ready, 0);
        tick(); #1;
        cfg_rdata = 32'h00000013;
        tick(); #1;
        chk("t6_lsu_resp_c3",  bus.lsu_resp_valid, 1);
        chk("t6_lsu_rdata",    bus.lsu_rdata,      32'h12345678);
        chk("t6_ifu_ready_c3", bus.ifu_req_ready,  0);
        tick(); #1;
        chk("t6_ifu_ready_c4", bus.ifu_req_ready,  1);
        chk("t6_lsu_resp_c4",  bus.lsu_resp_valid, 0);
        tick(); bus.ifu_req_valid = 1'b0;
        tick(); tick(); #1;
        chk("t6_ifu_resp_c7",  bus.ifu_resp_valid, 1);
        chk("t6_ifu_rdata",    bus.ifu_rdata,      32'h00000013);
        chk("t6_lsu_rdata_held", bus.lsu_rdata,    32'h12345678);

        // 5: asynchronous reset in the middle of a long WAIT
        tick();
        cfg_rsp_dly = 10; cfg_rdata = 32'h55AA55AA;
        bus.lsu_addr = 32'h80000008; bus.lsu_req_valid = 1'b1;
        #1 chk("t5_lsu_ready_c0", bus.lsu_req_ready, 1);
        tick(); tick(); tick();
        #1 chk("t5_busy_wait", busy, 1);
        rst = 1'b0;
        #1;
        chk("t5_busy",          busy,               0);
        chk("t5_mem_req_valid", bus.mem_req_valid,  0);
        chk("t5_mem_addr",      bus.mem_addr,       0);
        chk("t5_mem_wdata",     bus.mem_wdata,      0);
        chk("t5_lsu_ready",     bus.lsu_req_ready,  0);
        chk("t5_lsu_rdata",     bus.lsu_rdata,      0);
        chk("t5_ifu_rdata",     bus.ifu_rdata,      0);
        for (int c = 0; c < 3; c++) begin
            tick(); #1;
            chk("t5_no_resp",  bus.lsu_resp_valid, 0);
            chk("t5_ready_rst", bus.lsu_req_ready, 0);
        end
        bus.lsu_req_valid = 1'b0;
        rst = 1'b1;
        cfg_rsp_dly = 0; cfg_rdata = 32'h0000006F;
        tick();
        bus.ifu_addr = 32'h80000000; bus.ifu_req_valid = 1'b1;
        #1 chk("t5_ifu_ready_c0", bus.ifu_req_ready, 1);
        tick(); bus.ifu_req_valid = 1'b0;
        tick(); tick(); #1;
        chk("t5_ifu_resp_c3", bus.ifu_resp_valid, 1);
        chk("t5_ifu_rdata",   bus.ifu_rdata,      32'h0000006F);
        chk("t5_lsu_resp",    bus.lsu_resp_valid, 0);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
